execute_stage: RTL
==================

# execute_stage

Execute stage of the 5-stage pipeline: consumes the decode/execute pipeline register outputs, and forwards its results into the execute/memory pipeline register. It produces ALU results, resolves branches and jumps, and runs MUL/DIV as a multi-cycle iterative operation, stalling upstream stages while it is busy.

## Interface
Parameters:
- XLEN, 32, datapath width.
- MD_ITER, 32, iterations per MUL/DIV operation.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- de_valid_i  in  1  the decode/execute register holds a real instruction.
- de_pc_i  in  32  instruction address.
- de_opcode_i  in  7  opcode.
- de_funct3_i  in  3  funct3 field.
- de_rd_i  in  5  destination register.
- de_read_data1_i, de_read_data2_i  in  32  register-file operands.
- de_offset_i  in  32  sign-extended immediate.
- de_alusrc1_i  in  1  operand A select: 0 = rs1, 1 = PC.
- de_alusrc2_i  in  1  operand B select: 0 = rs2, 1 = offset.
- de_alu_op_i  in  6  ALU operation code.
- de_jump_i  in  1  JAL or JALR.
- fwd_a_sel_i, fwd_b_sel_i  in  2  forwarding select: 00 = register file, 01 = mem_fwd_data_i, 10 = wb_fwd_data_i.
- mem_fwd_data_i, wb_fwd_data_i  in  32  forwarded values.
- flush_i  in  1  kill the current instruction.
- ex_valid_o  out  1  result is valid this cycle.
- ex_result_o  out  32  ALU, MUL/DIV, or link result.
- ex_store_data_o  out  32  forwarded rs2 value.
- ex_rd_o  out  5  destination register (passthrough).
- ex_stall_o  out  1  freeze PC, fetch/decode and decode/execute registers.
- ex_redirect_o  out  1  a taken branch or jump.
- ex_redirect_pc_o  out  32  redirect target.
- ex_illegal_o  out  1  unsupported operation.

## Operation
- Forwarding muxes are applied first. A = alusrc1 ? pc : fwdA. B = alusrc2 ? offset : fwdB.
- Single-cycle ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB.
  - Shift amounts use B[4:0].
  - Results wrap modulo 2^32.
- Branch (opcode 1100011): compare fwdA and fwdB by funct3 (BEQ, BNE, BLT, BGE, BLTU, BGEU). If taken, assert redirect with target pc + offset.
- JAL: target = pc + offset. JALR: target = (fwdA + offset) & ~1. For both, result = pc + 4 and redirect is asserted.
- MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU use an FSM:
  - IDLE: on a valid MUL/DIV op, latch operands and signedness, assert stall, go to BUSY.
  - BUSY: perform one shift-add or restoring-subtract step per cycle. The counter runs 0 to MD_ITER-1 with stall held high; at MD_ITER-1 go to DONE.
  - DONE: stall low, ex_valid_o high, result presented; go to IDLE.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- Redirect, valid and illegal outputs are all gated by de_valid_i and !flush_i.

## Timing
- Reset values: FSM in IDLE, counter 0, operand and accumulator registers 0. All outputs are 0, including ex_stall_o and ex_redirect_o.
- ALU, branch and jump ops are combinational: the result is valid in the same cycle the instruction sits in the decode/execute register.
- MUL/DIV latency: 1 IDLE cycle + MD_ITER BUSY cycles + 1 DONE cycle, i.e. 34 cycles with defaults.
  - ex_stall_o is high for the first 33 of those cycles.
  - ex_valid_o is low until DONE.
- flush_i in any state: return to IDLE on the next edge and drop stall the next cycle. ex_valid_o and ex_redirect_o are 0 in the same cycle.
- Reset asserted mid-operation: immediate return to IDLE; the result is discarded.
- The next instruction arrives only after DONE, so back-to-back MUL/DIV ops re-enter IDLE cleanly.

## Configuration
- EXECUTE_DIV_EN defined: DIV, DIVU, REM and REMU go through the iterative FSM.
- Undefined: those ops complete in a single cycle with result 0 and ex_illegal_o=1, and never stall. Multiply is unaffected.

## Structure
- The shared package pipeline_pkg holds:
  - the ALU op codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10, MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23;
  - the opcode constants OP_BRANCH, OP_JAL, OP_JALR;
  - the forwarding-select constants;
  - the FSM state typedef (IDLE, BUSY, DONE).
- One sub-module, muldiv_unit, holds the FSM, counter and iterative datapath.

## Test plan
- ADD with A=0x7FFFFFFF, B=1 -> result 0x80000000, no stall.
- BEQ with equal operands, pc=0x100, offset=0x20 -> redirect=1, redirect_pc=0x120. BNE with the same operands -> redirect=0.
- JALR with rs1=0x203, offset=4 -> redirect_pc=0x206, result=pc+4.
- MUL with -3 × 7 -> stall held 33 cycles, then result 0xFFFFFFEB (-21) with valid for 1 cycle. MULHU with 0xFFFFFFFF × 0xFFFFFFFF -> result 0xFFFFFFFE.
- DIV by 0 with dividend 5 -> quotient 0xFFFFFFFF, REM -> 5. DIV 0x80000000 / -1 -> 0x80000000. Without EXECUTE_DIV_EN: result 0, illegal=1, no stall.
- Assert flush_i at BUSY cycle 10 -> stall drops the next cycle, valid never rises. Assert reset mid-MUL -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants and types for the execute stage.
//   - ALU operation codes (alu_op_e), with MUL/DIV occupying 16..23
//   - low-bit MUL/DIV sub-op codes seen by muldiv_unit
//   - opcode constants for branch / JAL / JALR
//   - branch funct3 codes
//   - forwarding-select constants
//   - MUL/DIV FSM state type
package pipeline_pkg;

    typedef enum logic [5:0] {
        ALU_ADD    = 6'd0,
        ALU_SUB    = 6'd1,
        ALU_SLL    = 6'd2,
        ALU_SLT    = 6'd3,
        ALU_SLTU   = 6'd4,
        ALU_XOR    = 6'd5,
        ALU_SRL    = 6'd6,
        ALU_SRA    = 6'd7,
        ALU_OR     = 6'd8,
        ALU_AND    = 6'd9,
        ALU_PASSB  = 6'd10,
        ALU_MUL    = 6'd16,
        ALU_MULH   = 6'd17,
        ALU_MULHSU = 6'd18,
        ALU_MULHU  = 6'd19,
        ALU_DIV    = 6'd20,
        ALU_DIVU   = 6'd21,
        ALU_REM    = 6'd22,
        ALU_REMU   = 6'd23
    } alu_op_e;

    // Low three bits of the MUL/DIV ALU codes; bit 2 set means divide.
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(input logic [5:0] op);
        return op[5:3] == 3'b010;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiplier / restoring divider.
//   Works on operand magnitudes and fixes signs when the result is presented.
// Ports:
//   clk_i, reset_i     clock, async active-high reset
//   start_i            launch an operation (sampled only in IDLE)
//   flush_i            abandon the current operation, back to IDLE
//   op_i [2:0]         MUL/DIV sub-op (low bits of the ALU code)
//   a_i, b_i           multiplicand/dividend, multiplier/divisor
//   busy_o             in BUSY
//   done_o             in DONE, result_o holds the answer
//   result_o           final result (meaningful while done_o)
//
// state | meaning
// IDLE  | waiting; operands latched on start_i
// BUSY  | one shift-add / restoring-subtract step per cycle
// DONE  | result presented for one cycle
module muldiv_unit
    import pipeline_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MD_ITER = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(MD_ITER - 1);

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              bzero_q, bzero_d;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quo, rem, quo_s, rem_s;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op_i)
            MD_MULH:        begin a_signed = 1'b1; b_signed = 1'b1; end
            MD_MULHSU:      a_signed = 1'b1;
            MD_DIV, MD_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
            default:        ;
        endcase
    end

    assign a_neg = a_signed & a_i[XLEN-1];
    assign b_neg = b_signed & b_i[XLEN-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // Multiply: {hi, lo} with the multiplier in lo, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: {remainder, quotient} shifted left, quotient bits enter at lsb.
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        dvd_d   = dvd_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    b_d     = b_mag;
                    dvd_d   = a_i;
                    op_d    = op_i;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    bzero_d = (b_i == '0);
                end
            end
            BUSY: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            dvd_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            dvd_q   <= dvd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
        end
    end

    assign prod  = neg_q ? -acc_q : acc_q;
    assign quo   = acc_q[XLEN-1:0];
    assign rem   = acc_q[2*XLEN-1:XLEN];
    assign quo_s = neg_q ? -quo : quo;
    assign rem_s = rneg_q ? -rem : rem;

    // Divide-by-zero bypasses the sign fix-up; signed overflow falls out
    // of the magnitude path naturally (0x80000000 / 1, negated).
    always_comb begin
        result_o = '0;
        case (op_q)
            MD_MUL:                          result_o = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:    result_o = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:                 result_o = bzero_q ? '1 : quo_s;
            default:                         result_o = bzero_q ? dvd_q : rem_s;
        endcase
    end

    assign busy_o = (state_q == BUSY);
    assign done_o = (state_q == DONE);

endmodule

// File: rtl/execute_stage.sv
// execute_stage: pipeline execute stage.
//   Operand forwarding, single-cycle ALU, branch/jump resolution, and an
//   iterative MUL/DIV (muldiv_unit) that stalls upstream while busy.
// Build option: EXECUTE_DIV_EN -- when defined DIV/DIVU/REM/REMU run on the
//   iterative unit; otherwise they finish in one cycle as illegal with result 0.
// Ports:
//   clk_i, reset_i           clock, async active-high reset
//   de_*                     decode/execute register contents
//   fwd_a_sel_i/fwd_b_sel_i  operand source: RF, mem_fwd_data_i, wb_fwd_data_i
//   flush_i                  kill the current instruction
//   ex_valid_o, ex_result_o, ex_store_data_o, ex_rd_o   to execute/memory reg
//   ex_stall_o               freeze PC, fetch/decode and decode/execute regs
//   ex_redirect_o, ex_redirect_pc_o   taken branch / jump and its target
//   ex_illegal_o             unsupported operation
module execute_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MD_ITER = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            de_valid_i,
    input  logic [XLEN-1:0] de_pc_i,
    input  logic [6:0]      de_opcode_i,
    input  logic [2:0]      de_funct3_i,
    input  logic [4:0]      de_rd_i,
    input  logic [XLEN-1:0] de_read_data1_i,
    input  logic [XLEN-1:0] de_read_data2_i,
    input  logic [XLEN-1:0] de_offset_i,
    input  logic            de_alusrc1_i,
    input  logic            de_alusrc2_i,
    input  logic [5:0]      de_alu_op_i,
    input  logic            de_jump_i,
    input  logic [1:0]      fwd_a_sel_i,
    input  logic [1:0]      fwd_b_sel_i,
    input  logic [XLEN-1:0] mem_fwd_data_i,
    input  logic [XLEN-1:0] wb_fwd_data_i,
    input  logic            flush_i,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_result_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [4:0]      ex_rd_o,
    output logic            ex_stall_o,
    output logic            ex_redirect_o,
    output logic [XLEN-1:0] ex_redirect_pc_o,
    output logic            ex_illegal_o
);

    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b;
    logic [XLEN-1:0] alu_res, md_result, link_pc, jalr_sum, br_target;
    logic [4:0]      shamt;
    logic            alu_ok, br_ok, taken;
    logic            is_branch, is_jalr, is_md, md_take, div_off;
    logic            live, md_start, md_busy, md_done;

    always_comb begin
        case (fwd_a_sel_i)
            FWD_MEM: fwd_a = mem_fwd_data_i;
            FWD_WB:  fwd_a = wb_fwd_data_i;
            default: fwd_a = de_read_data1_i;
        endcase
        case (fwd_b_sel_i)
            FWD_MEM: fwd_b = mem_fwd_data_i;
            FWD_WB:  fwd_b = wb_fwd_data_i;
            default: fwd_b = de_read_data2_i;
        endcase
    end

    assign op_a  = de_alusrc1_i ? de_pc_i : fwd_a;
    assign op_b  = de_alusrc2_i ? de_offset_i : fwd_b;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (de_alu_op_i)
            ALU_ADD:   alu_res = op_a + op_b;
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_SLL:   alu_res = op_a << shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_SRL:   alu_res = op_a >> shamt;
            ALU_SRA:   alu_res = XLEN'($signed(op_a) >>> shamt);
            ALU_OR:    alu_res = op_a | op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_PASSB: alu_res = op_b;
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: alu_res = '0;
            default:   alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        br_ok = 1'b1;
        case (de_funct3_i)
            F3_BEQ:  taken = (fwd_a == fwd_b);
            F3_BNE:  taken = (fwd_a != fwd_b);
            F3_BLT:  taken = ($signed(fwd_a) <  $signed(fwd_b));
            F3_BGE:  taken = ($signed(fwd_a) >= $signed(fwd_b));
            F3_BLTU: taken = (fwd_a <  fwd_b);
            F3_BGEU: taken = (fwd_a >= fwd_b);
            default: br_ok = 1'b0;
        endcase
    end

    assign is_branch = (de_opcode_i == OP_BRANCH);
    assign is_jalr   = (de_opcode_i == OP_JALR);
    assign is_md     = !is_branch && !de_jump_i && is_muldiv(de_alu_op_i);

`ifdef EXECUTE_DIV_EN
    assign md_take = is_md;
    assign div_off = 1'b0;
`else
    assign md_take = is_md && !de_alu_op_i[2];
    assign div_off = is_md && de_alu_op_i[2];
`endif

    assign live     = de_valid_i && !flush_i && !reset_i;
    // The instruction stays in decode/execute through DONE, so a new start
    // is only possible once the unit is back in IDLE.
    assign md_start = live && md_take && !md_busy && !md_done;

    muldiv_unit #(
        .XLEN    (XLEN),
        .MD_ITER (MD_ITER)
    ) u_muldiv (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (md_start),
        .flush_i  (flush_i),
        .op_i     (de_alu_op_i[2:0]),
        .a_i      (op_a),
        .b_i      (op_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    assign link_pc   = de_pc_i + XLEN'(4);
    assign jalr_sum  = fwd_a + de_offset_i;
    assign br_target = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (de_pc_i + de_offset_i);

    always_comb begin
        ex_result_o = '0;
        if (!reset_i) begin
            if (de_jump_i) begin
                ex_result_o = link_pc;
            end else if (md_take) begin
                ex_result_o = md_done ? md_result : '0;
            end else if (!div_off) begin
                ex_result_o = alu_res;
            end
        end
    end

    assign ex_valid_o       = live && (md_take ? md_done : 1'b1);
    assign ex_stall_o       = !reset_i && (md_start || md_busy);
    assign ex_redirect_o    = live && (de_jump_i || (is_branch && taken));
    assign ex_redirect_pc_o = ex_redirect_o ? br_target : '0;
    assign ex_illegal_o     = live && (div_off ||
                              (is_branch ? !br_ok : (!de_jump_i && !alu_ok)));
    assign ex_store_data_o  = reset_i ? '0 : fwd_b;
    assign ex_rd_o          = reset_i ? '0 : de_rd_i;

endmodule
